// File: rtl/fsm_seq_pkg.sv
// rtl/fsm_seq_pkg.sv - shared types, phase code table and phase stepping for the sequence checker
package fsm_seq_pkg;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCKED   = 2'd1,
      ERROR    = 2'd2
   } state_t;

   localparam int SEQ_LEN = 6;
   localparam logic [2:0] LAST_PHASE = 3'(SEQ_LEN - 1);

   localparam logic [3:0] SEQ_CODE [0:SEQ_LEN-1] = '{
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010
   };

   function automatic logic [2:0] next_phase(input logic [2:0] idx);
      return (idx == LAST_PHASE) ? 3'd0 : idx + 3'd1;
   endfunction

endpackage

// File: rtl/fsm_seq_checker_sat_counter.sv
// rtl/fsm_seq_checker_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/fsm_seq_checker.sv
// rtl/fsm_seq_checker.sv - monitor for the mod-6 phase sequencer; FSM_SEQ_CHK_AUTO_RESYNC_EN lets ERROR relock on 0001
module fsm_seq_checker
   import fsm_seq_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int ERR_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic             clr,
   input  logic [3:0]       y,
   output logic             locked,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [2:0]       phase,
   output logic             cyc_pulse
);

   state_t           r_state;
   logic [2:0]       r_phase;
   logic             r_locked;
   logic             r_err;
   logic [CNT_W-1:0] r_cyc_cnt;
   logic             r_cyc_pulse;

   logic [2:0]       w_next;
   logic [3:0]       w_exp;
   logic             w_match;
   logic             w_err_inc;

   // Codes repeat within a cycle, so the expected word always comes from the tracked index.
   assign w_next    = next_phase(r_phase);
   assign w_exp     = ld ? SEQ_CODE[w_next] : SEQ_CODE[r_phase];
   assign w_match   = (y == w_exp);
   assign w_err_inc = (r_state == LOCKED) && !w_match && !clr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= UNLOCKED;
         r_phase     <= 3'd0;
         r_locked    <= 1'b0;
         r_err       <= 1'b0;
         r_cyc_cnt   <= '0;
         r_cyc_pulse <= 1'b0;
      end else begin
         r_cyc_pulse <= 1'b0;
         if (clr) begin
            r_state   <= UNLOCKED;
            r_phase   <= 3'd0;
            r_locked  <= 1'b0;
            r_err     <= 1'b0;
            r_cyc_cnt <= '0;
         end else begin
            case (r_state)
               UNLOCKED: begin
                  if (y == SEQ_CODE[0]) begin
                     r_state  <= LOCKED;
                     r_phase  <= 3'd0;
                     r_locked <= 1'b1;
                  end
               end
               LOCKED: begin
                  if (!w_match) begin
                     r_state  <= ERROR;
                     r_locked <= 1'b0;
                     r_err    <= 1'b1;
                  end else if (ld) begin
                     r_phase <= w_next;
                     if (r_phase == LAST_PHASE) begin
                        r_cyc_cnt   <= r_cyc_cnt + 1'b1;
                        r_cyc_pulse <= 1'b1;
                     end
                  end
               end
               ERROR: begin
`ifdef FSM_SEQ_CHK_AUTO_RESYNC_EN
                  // err and err_cnt stay as they are so the violation history survives the relock.
                  if (y == SEQ_CODE[0]) begin
                     r_state  <= LOCKED;
                     r_phase  <= 3'd0;
                     r_locked <= 1'b1;
                  end
`else
                  r_state <= ERROR;
`endif
               end
               default: begin
                  r_state  <= UNLOCKED;
                  r_phase  <= 3'd0;
                  r_locked <= 1'b0;
               end
            endcase
         end
      end
   end

   sat_counter #(
      .W(ERR_W)
   ) u_err_cnt (
      .i_clk  (clk),
      .i_rst_n(rst),
      .i_inc  (w_err_inc),
      .i_clr  (clr),
      .o_count(err_cnt)
   );

   assign locked    = r_locked;
   assign err       = r_err;
   assign cyc_cnt   = r_cyc_cnt;
   assign phase     = r_phase;
   assign cyc_pulse = r_cyc_pulse;

endmodule
